// File: rtl/axis_byte_transform.sv
// axis_byte_transform: AXI-Stream byte transformer with a FIFO_DEPTH-beat buffer.
// Each byte is passed, inverted, XORed with KEY or thresholded against KEY.
// The byte is transformed as it is written into the FIFO.
// MODE/KEY are sampled on the first beat of a packet and held until TLAST.
// Optional statistics counters are built only when AXIS_BYTE_TRANSFORM_STATS_EN is defined.
// Without that macro, PKT_COUNT and BEAT_COUNT are tied to zero.
module axis_byte_transform #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [1:0]                    MODE,
  input  logic [7:0]                    KEY,
  input  logic [DATA_WIDTH-1:0]         S_AXIS_TDATA,
  input  logic                          S_AXIS_TVALID,
  output logic                          S_AXIS_TREADY,
  input  logic                          S_AXIS_TLAST,
  output logic [DATA_WIDTH-1:0]         M_AXIS_TDATA,
  output logic                          M_AXIS_TVALID,
  input  logic                          M_AXIS_TREADY,
  output logic                          M_AXIS_TLAST,
  output logic [$clog2(FIFO_DEPTH):0]   OCCUPANCY,
  output logic [31:0]                   PKT_COUNT,
  output logic [31:0]                   BEAT_COUNT
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [AW:0]   CNT_FULL = FIFO_DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  typedef enum logic [0:0] {StIdle, StInPkt} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [1:0]            r_mode;
  logic [1:0]            w_mode_next;
  logic [7:0]            r_key;
  logic [7:0]            w_key_next;

  // Each entry holds {tlast, data}.
  logic [DATA_WIDTH:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;

  logic                  w_s_ready;
  logic                  w_m_valid;
  logic                  w_wr;
  logic                  w_rd;
  logic [1:0]            w_mode;
  logic [7:0]            w_key;
  logic [DATA_WIDTH-1:0] w_xdata;
  logic [DATA_WIDTH:0]   w_head;

  // Handshakes. Ready depends only on the occupancy register and RESET,
  // never on M_AXIS_TREADY.
  always_comb begin
    w_s_ready = !RESET && (r_count != CNT_FULL);
    w_m_valid = !RESET && (r_count != '0);
    w_wr      = S_AXIS_TVALID && w_s_ready;
    w_rd      = w_m_valid && M_AXIS_TREADY;
  end

  // Pick the operand set: live inputs on a packet's first beat, latched ones after that.
  always_comb begin
    w_mode = (r_state == StIdle) ? MODE : r_mode;
    w_key  = (r_state == StIdle) ? KEY  : r_key;
  end

  // Transform each byte lane independently.
  always_comb begin
    w_xdata = '0;
    for (int i = 0; i < NB; i++) begin
      unique case (w_mode)
        2'd0: w_xdata[8*i +: 8] = S_AXIS_TDATA[8*i +: 8];
        2'd1: w_xdata[8*i +: 8] = ~S_AXIS_TDATA[8*i +: 8];
        2'd2: w_xdata[8*i +: 8] = S_AXIS_TDATA[8*i +: 8] ^ w_key;
        2'd3: w_xdata[8*i +: 8] = (S_AXIS_TDATA[8*i +: 8] >= w_key) ? 8'hFF : 8'h00;
        default: w_xdata[8*i +: 8] = S_AXIS_TDATA[8*i +: 8];
      endcase
    end
  end

  // Packet state register together with the latched operands.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= StIdle;
      r_mode  <= 2'd0;
      r_key   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_mode  <= w_mode_next;
      r_key   <= w_key_next;
    end
  end

  // Next packet state. The operands are latched on every beat accepted in IDLE.
  always_comb begin
    w_state_next = r_state;
    w_mode_next  = r_mode;
    w_key_next   = r_key;
    unique case (r_state)
      StIdle: begin
        if (w_wr) begin
          w_mode_next = MODE;
          w_key_next  = KEY;
          if (!S_AXIS_TLAST) w_state_next = StInPkt;
        end
      end
      StInPkt: begin
        if (w_wr && S_AXIS_TLAST) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // FIFO storage. The storage is not reset because the outputs are masked while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_wr_ptr] <= {S_AXIS_TLAST, w_xdata};
  end

  // FIFO pointers and occupancy. The power-of-two depth makes the pointers wrap naturally.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output side. Data and last read as zero whenever nothing is buffered.
  always_comb begin
    w_head        = r_mem[r_rd_ptr];
    S_AXIS_TREADY = w_s_ready;
    M_AXIS_TVALID = w_m_valid;
    M_AXIS_TDATA  = w_m_valid ? w_head[DATA_WIDTH-1:0] : '0;
    M_AXIS_TLAST  = w_m_valid ? w_head[DATA_WIDTH] : 1'b0;
    OCCUPANCY     = r_count;
  end

`ifdef AXIS_BYTE_TRANSFORM_STATS_EN
  logic [31:0] r_pkt_count;
  logic [31:0] r_beat_count;

  // Count beats and packets leaving on the M side. Both counters wrap at 2^32.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pkt_count  <= 32'd0;
      r_beat_count <= 32'd0;
    end else if (w_rd) begin
      r_beat_count <= r_beat_count + 32'd1;
      if (w_head[DATA_WIDTH]) r_pkt_count <= r_pkt_count + 32'd1;
    end
  end

  assign PKT_COUNT  = r_pkt_count;
  assign BEAT_COUNT = r_beat_count;
`else
  assign PKT_COUNT  = 32'd0;
  assign BEAT_COUNT = 32'd0;
`endif

endmodule
